// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned SLICE_DEF = 4;
  localparam int unsigned N         = WIDTH_DEF / SLICE_DEF;
  localparam int unsigned CNT_W     = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // One-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

endpackage

// File: rtl/serial_sub32_sub_slice.sv
// Combinational SLICE-bit borrow-ripple subtractor built from full subtractors.
module sub_slice
  import serial_sub_pkg::*;
#(
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic       c;
  logic [1:0] fs;

  always_comb begin
    c  = bin;
    fs = '0;
    d  = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      fs   = full_sub(a[i], b[i], c);
      d[i] = fs[0];
      c    = fs[1];
    end
    bout = c;
  end

endmodule

// File: rtl/serial_sub32.sv
// Nibble-serial subtractor: diff = a - b - bin over WIDTH/SLICE cycles.
// Optional result flags (zero/neg/ovf) are built when SUB_FLAGS_EN is defined.
module serial_sub32
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

  if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $error("serial_sub32: WIDTH must be a nonzero multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic              borrow_q, borrow_d, bout_q, bout_d, out_valid_q, out_valid_d;
  logic [SLICE-1:0]  sl_d;
  logic              sl_bout, last;
`ifdef SUB_FLAGS_EN
  logic              zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
`endif

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .bin  (borrow_q),
    .d    (sl_d),
    .bout (sl_bout)
  );

  assign last = (cnt_q == CW'(NS - 1));

  // Operands shift right so the active slice is always in the low bits;
  // results shift in from the top and land in place after NS cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    borrow_d    = borrow_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
`ifdef SUB_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d                    = a_q >> SLICE;
        b_d                    = b_q >> SLICE;
        diff_d                 = diff_q >> SLICE;
        diff_d[WIDTH-1 -: SLICE] = sl_d;
        borrow_d               = sl_bout;
        if (last) begin
          bout_d      = sl_bout;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SUB_FLAGS_EN
          zero_d      = (diff_d == '0);
          neg_d       = sl_d[SLICE-1];
          ovf_d       = (a_q[SLICE-1] != b_q[SLICE-1]) && (sl_d[SLICE-1] != a_q[SLICE-1]);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
`ifdef SUB_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub32.sv
// Directed scoreboard bench for serial_sub32.
module tb_serial_sub32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        bin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, bout;
  logic [31:0] diff;
`ifdef SUB_FLAGS_EN
  logic        zero, neg, ovf;
`endif

  serial_sub32 #(.WIDTH(32), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    exp_t        e;
    logic [32:0] r;
    r      = {1'b0, av} - {1'b0, bv} - {32'd0, bi};
    e.diff = r[31:0];
    e.bout = r[32];
    e.zero = (r[31:0] == 32'd0);
    e.neg  = r[31];
    e.ovf  = (av[31] != bv[31]) && (r[31] != av[31]);
    return e;
  endfunction

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    sb.push_back(model(av, bv, bi));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input int stall, input bit pulse);
    int   cyc = 0;
    exp_t e;
    logic [31:0] d0;
    logic        b0;
    while (!out_valid && cyc < 50) begin
      if (pulse && cyc == 3) begin
        check("in_ready_run", {31'd0, in_ready}, 32'd0);
        a        = ~a;
        b        = ~b;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc++;
    end
    check("latency", cyc, 32'd8);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, {31'd0, out_valid & 1'b0});
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("diff", diff, e.diff);
    check("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SUB_FLAGS_EN
    check("zero", {31'd0, zero}, {31'd0, e.zero});
    check("neg",  {31'd0, neg},  {31'd0, e.neg});
    check("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
`endif
    d0 = e.diff;
    b0 = e.bout;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
      check("stall_diff", diff, d0);
      check("stall_bout", {31'd0, bout}, {31'd0, b0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid_low", {31'd0, out_valid}, 32'd0);
    check("hs_in_ready", {31'd0, in_ready}, 32'd1);
    if (pulse) begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("no_queued_op", {31'd0, out_valid}, 32'd0);
      check("still_idle", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_FLAGS_EN
    check("rst_flags", {29'd0, zero, neg, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_op(32'h0000_0005, 32'h0000_0003, 1'b0); finish_op(0, 1'b0);
    start_op(32'h0000_0000, 32'h0000_0001, 1'b0); finish_op(0, 1'b0);
    start_op(32'h8000_0000, 32'h0000_0001, 1'b0); finish_op(0, 1'b0);
    start_op(32'h1234_5678, 32'h1234_5678, 1'b0); finish_op(0, 1'b0);
    start_op(32'h1234_5678, 32'h1234_5678, 1'b1); finish_op(0, 1'b0);
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1); finish_op(5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
      finish_op(i, 1'b0);
    end

    // Abort mid-RUN: reset lands while slice 3 is being computed.
    start_op(32'h1234_5678, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_diff", diff, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_stale", {31'd0, seen}, 32'd0);

    start_op(32'h0000_0010, 32'h0000_0001, 1'b0); finish_op(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
